// File: rtl/inst_encoder_if.sv
// inst_encoder_if: sequencer-to-encoder field-level command handshake
interface inst_encoder_if #(
    parameter int OPCODE_LEN = 3,
    parameter int REG_LEN    = 4,
    parameter int SIMM_LEN   = 5,
    parameter int LIMM_LEN   = 8
);
    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [OPCODE_LEN-1:0] cmd_opcode_i;
    logic [REG_LEN-1:0]    cmd_rd_i;
    logic [REG_LEN-1:0]    cmd_rs1_i;
    logic [REG_LEN-1:0]    cmd_rs2_i;
    logic                  cmd_func_i;
    logic [SIMM_LEN-1:0]   cmd_simm_i;
    logic [LIMM_LEN-1:0]   cmd_limm_i;
    modport master (
        output cmd_valid_i, cmd_opcode_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i,
               cmd_func_i, cmd_simm_i, cmd_limm_i,
        input  cmd_ready_o
    );
    modport slave (
        input  cmd_valid_i, cmd_opcode_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i,
               cmd_func_i, cmd_simm_i, cmd_limm_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/inst_encoder.sv
// inst_encoder: packs commands into 16-bit words, buffers and issues them; NPU_ENC_ILLEGAL_CHECK_EN drops reserved opcodes and pulses err_o
module inst_encoder #(
    parameter int INST_LEN   = 16,
    parameter int OPCODE_LEN = 3,
    parameter int REG_LEN    = 4,
    parameter int SIMM_LEN   = 5,
    parameter int LIMM_LEN   = 8,
    parameter int DEPTH      = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_encoder_if.slave       cmd,
    input  logic                stall_i,
    input  logic                flush_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    output logic                empty_o,
    output logic [15:0]         issued_cnt_o,
    output logic                err_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [INST_LEN-1:0] BUBBLE = 16'hE000;

    logic [INST_LEN-1:0]   mem_q [DEPTH];
    logic [INST_LEN-1:0]   word, inst_q, inst_d;
    logic [OPCODE_LEN-1:0] op;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]           count_q, count_d;
    logic [15:0]           issued_q, issued_d;
    logic                  inst_valid_q, inst_valid_d;
    logic                  illegal, fire, push, pop;

    assign op = cmd.cmd_opcode_i;

    // x00 load-format, x01 store-format, 010 mov; everything else takes the VMAC layout
    always_comb begin
        word = op[1:0] == 2'b00 ? {op, cmd.cmd_rd_i, cmd.cmd_rs1_i, cmd.cmd_simm_i}
             : op[1:0] == 2'b01 ? {op, {REG_LEN{1'b0}}, cmd.cmd_rs1_i, cmd.cmd_rs2_i, cmd.cmd_func_i}
             : op == 3'b010     ? {op, cmd.cmd_rd_i, cmd.cmd_limm_i, cmd.cmd_func_i}
             :                    {op, cmd.cmd_rd_i, cmd.cmd_rs1_i, cmd.cmd_rs2_i, cmd.cmd_func_i};
    end

`ifdef NPU_ENC_ILLEGAL_CHECK_EN
    logic err_q;
    assign illegal = &op[1:0];
    always_ff @(posedge clk) begin
        err_q <= rst_n && fire && illegal;
    end
    assign err_o = err_q;
`else
    assign illegal = 1'b0;
    assign err_o   = 1'b0;
`endif

    assign cmd.cmd_ready_o = !flush_i && !count_q[PW];
    assign fire = cmd.cmd_valid_i && cmd.cmd_ready_o;
    assign push = fire && !illegal;
    assign pop  = !flush_i && !stall_i && |count_q;

    always_comb begin
        count_d      = flush_i ? '0 : count_q + (PW+1)'(push) - (PW+1)'(pop);
        wr_ptr_d     = flush_i ? '0 : wr_ptr_q + PW'(push);
        rd_ptr_d     = flush_i ? '0 : rd_ptr_q + PW'(pop);
        inst_d       = flush_i ? BUBBLE : stall_i ? inst_q : pop ? mem_q[rd_ptr_q] : BUBBLE;
        inst_valid_d = flush_i ? 1'b0 : stall_i ? inst_valid_q : pop;
        issued_d     = issued_q + 16'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            inst_q       <= BUBBLE;
            inst_valid_q <= 1'b0;
            issued_q     <= '0;
        end else begin
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            issued_q     <= issued_d;
        end
    end

    assign inst_o       = inst_q;
    assign inst_valid_o = inst_valid_q;
    assign empty_o      = ~|count_q;
    assign issued_cnt_o = issued_q;
endmodule
